sif_xa_wa_bridge: RTL and testbench

- Parametrised successor to the single-register SIF XA/WA data path.
- XA side writes words into a DEPTH-deep FIFO that drains toward the WA side through a valid/ack handshake.
- WA side writes a return word that XA reads back through a read strobe.
- Flags illegal XA operations (simultaneous write and read, write while full) with an error pulse.

---
 rtl/sif_xa_wa_bridge.sv | 160 ++++++++++++++++
 tb/tb_sif_xa_wa_bridge.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sif_xa_wa_bridge.sv
// -----------------------------------------------------------------------------
// sif_xa_wa_bridge
// XA -> WA word FIFO (first-word-fall-through) plus a WA -> XA return register.
//
// Parameters:
//   DATA_W    : width of every data port and of storage
//   DEPTH     : FIFO entries, power of two, >= 2
//   ERR_CNT_W : width of err_cnt (only with SIF_BRIDGE_ERR_CNT_EN)
//
// Ports:
//   clk, rst_n      : clock (rising edge), async active-low reset
//   xa_wr_s/xa_wr_data : XA push strobe and word
//   xa_rd_s         : XA read strobe for the return register
//   xa_rd_data      : registered return word
//   xa_rd_valid_s   : one-cycle pulse, xa_rd_data updated
//   xa_full         : FIFO holds DEPTH words
//   xa_err_s        : one-cycle pulse on illegal (wr+rd) or dropped (wr while full) op
//   wa_valid_s/wa_data : FIFO head presentation (wa_data is 0 when empty)
//   wa_ack_s        : WA pops the head when wa_valid_s=1
//   wa_wr_s/wa_wr_data : WA return-register write
//   level           : FIFO occupancy, 0..DEPTH
//
// Optional feature macro: SIF_BRIDGE_ERR_CNT_EN
//   Adds output err_cnt[ERR_CNT_W-1:0], a saturating count of xa_err_s pulses,
//   cleared only by rst_n.
// -----------------------------------------------------------------------------
module sif_xa_wa_bridge #(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     xa_wr_s,
  input  logic [DATA_W-1:0]        xa_wr_data,
  input  logic                     xa_rd_s,
  output logic [DATA_W-1:0]        xa_rd_data,
  output logic                     xa_rd_valid_s,
  output logic                     xa_full,
  output logic                     xa_err_s,
  output logic                     wa_valid_s,
  output logic [DATA_W-1:0]        wa_data,
  input  logic                     wa_ack_s,
  input  logic                     wa_wr_s,
  input  logic [DATA_W-1:0]        wa_wr_data,
  output logic [$clog2(DEPTH):0]   level
`ifdef SIF_BRIDGE_ERR_CNT_EN
  ,output logic [ERR_CNT_W-1:0]    err_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  // Width parameter must be at least one bit; an empty block keeps it referenced
  // in builds where the counter is absent.
  if (ERR_CNT_W < 1) begin : g_err_cnt_w_invalid
  end

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [LVL_W-1:0]  level_r;
  logic [DATA_W-1:0] ret_r;
  logic [DATA_W-1:0] rd_data_r;
  logic              rd_valid_r;
  logic              err_r;

  logic              full_s;
  logic              nonempty_s;
  logic              push_s;
  logic              pop_s;
  logic              rd_ok_s;
  logic              err_nxt_s;
  logic [LVL_W-1:0]  level_nxt_s;

  assign full_s     = (level_r == LVL_W'(DEPTH));
  assign nonempty_s = (level_r != {LVL_W{1'b0}});

  // XA decode and FIFO occupancy update; full is judged on registered state so a
  // same-cycle pop never rescues a push into a full FIFO.
  always_comb begin
    push_s      = 1'b0;
    rd_ok_s     = 1'b0;
    err_nxt_s   = 1'b0;
    pop_s       = nonempty_s & wa_ack_s;
    level_nxt_s = level_r;
    case ({xa_wr_s, xa_rd_s})
      2'b10: begin
        if (full_s) begin
          err_nxt_s = 1'b1;
        end else begin
          push_s = 1'b1;
        end
      end
      2'b01:   rd_ok_s   = 1'b1;
      2'b11:   err_nxt_s = 1'b1;
      default: ;
    endcase
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + LVL_W'(1);
      2'b01:   level_nxt_s = level_r - LVL_W'(1);
      default: level_nxt_s = level_r;
    endcase
  end

  // Storage array; intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= xa_wr_data;
    end
  end

  // Pointers, occupancy, return register and registered XA pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      level_r    <= {LVL_W{1'b0}};
      ret_r      <= {DATA_W{1'b0}};
      rd_data_r  <= {DATA_W{1'b0}};
      rd_valid_r <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      // Pointers wrap naturally modulo DEPTH (power of two).
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      level_r <= level_nxt_s;
      // A same-cycle read sees the old return value.
      if (rd_ok_s) rd_data_r <= ret_r;
      if (wa_wr_s) ret_r <= wa_wr_data;
      rd_valid_r <= rd_ok_s;
      err_r      <= err_nxt_s;
    end
  end

`ifdef SIF_BRIDGE_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_r;

  // Saturating error counter, steps on the same edge as the xa_err_s pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_r <= {ERR_CNT_W{1'b0}};
    end else if (err_nxt_s && (err_cnt_r != {ERR_CNT_W{1'b1}})) begin
      err_cnt_r <= err_cnt_r + ERR_CNT_W'(1);
    end
  end

  assign err_cnt = err_cnt_r;
`endif

  assign xa_rd_data    = rd_data_r;
  assign xa_rd_valid_s = rd_valid_r;
  assign xa_err_s      = err_r;
  assign xa_full       = full_s;
  assign level         = level_r;
  assign wa_valid_s    = nonempty_s;
  assign wa_data       = nonempty_s ? mem_r[rd_ptr_r] : {DATA_W{1'b0}};

endmodule

// File: tb/tb_sif_xa_wa_bridge.sv
// Testbench for sif_xa_wa_bridge (DATA_W=16, DEPTH=4): directed vector table,
// hand-written wrap / async-reset sequences, then random traffic against a
// queue-based reference model.
module tb_sif_xa_wa_bridge;

  localparam int DW = 16;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          xa_wr_s, xa_rd_s, wa_ack_s, wa_wr_s;
  logic [DW-1:0] xa_wr_data, wa_wr_data;
  logic [DW-1:0] xa_rd_data, wa_data;
  logic          xa_rd_valid_s, xa_full, xa_err_s, wa_valid_s;
  logic [2:0]    level;
`ifdef SIF_BRIDGE_ERR_CNT_EN
  logic [7:0]    err_cnt;
`endif

  sif_xa_wa_bridge #(.DATA_W(DW), .DEPTH(DP), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .xa_wr_s(xa_wr_s), .xa_wr_data(xa_wr_data), .xa_rd_s(xa_rd_s),
    .xa_rd_data(xa_rd_data), .xa_rd_valid_s(xa_rd_valid_s),
    .xa_full(xa_full), .xa_err_s(xa_err_s),
    .wa_valid_s(wa_valid_s), .wa_data(wa_data), .wa_ack_s(wa_ack_s),
    .wa_wr_s(wa_wr_s), .wa_wr_data(wa_wr_data), .level(level)
`ifdef SIF_BRIDGE_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int          q[$];
  logic [DW-1:0] m_ret, m_rd_data;
  bit          m_rd_valid, m_err;
  int          m_errcnt;

  typedef struct {
    bit wr; logic [DW-1:0] wd; bit rd; bit ack; bit wwr; logic [DW-1:0] wwd;
    int e_level; bit e_full; bit e_valid; logic [DW-1:0] e_wa;
    bit e_rdv; logic [DW-1:0] e_rdd; bit e_err;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ret = '0; m_rd_data = '0; m_rd_valid = 0; m_err = 0; m_errcnt = 0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".level"}, 32'(level), 32'(q.size()));
    chk({tag, ".full"}, 32'(xa_full), 32'(q.size() == DP));
    chk({tag, ".valid"}, 32'(wa_valid_s), 32'(q.size() != 0));
    chk({tag, ".wa_data"}, 32'(wa_data), (q.size() != 0) ? 32'(q[0]) : 32'h0);
    chk({tag, ".rd_valid"}, 32'(xa_rd_valid_s), 32'(m_rd_valid));
    chk({tag, ".rd_data"}, 32'(xa_rd_data), 32'(m_rd_data));
    chk({tag, ".err"}, 32'(xa_err_s), 32'(m_err));
`ifdef SIF_BRIDGE_ERR_CNT_EN
    chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(m_errcnt));
`endif
  endtask

  // Apply one cycle of inputs, advance the model by the behavioural rules,
  // then compare after the edge.
  task automatic step(input bit wr, input logic [DW-1:0] wd, input bit rd,
                      input bit ack, input bit wwr, input logic [DW-1:0] wwd,
                      input string tag);
    bit full, pop;
    xa_wr_s = wr; xa_wr_data = wd; xa_rd_s = rd;
    wa_ack_s = ack; wa_wr_s = wwr; wa_wr_data = wwd;
    full = (q.size() == DP);
    pop  = (q.size() != 0) && ack;
    m_err = (wr && rd) || (wr && !rd && full);
    if (m_err && m_errcnt < 255) m_errcnt++;
    m_rd_valid = rd && !wr;
    if (m_rd_valid) m_rd_data = m_ret;
    if (pop) void'(q.pop_front());
    if (wr && !rd && !full) q.push_back(int'(wd));
    if (wwr) m_ret = wwd;
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  function automatic vec_t mk(bit wr, logic [DW-1:0] wd, bit rd, bit ack, bit wwr,
                              logic [DW-1:0] wwd, int el, bit ef, bit ev,
                              logic [DW-1:0] ew, bit erv, logic [DW-1:0] erd, bit ee);
    vec_t v;
    v.wr = wr; v.wd = wd; v.rd = rd; v.ack = ack; v.wwr = wwr; v.wwd = wwd;
    v.e_level = el; v.e_full = ef; v.e_valid = ev; v.e_wa = ew;
    v.e_rdv = erv; v.e_rdd = erd; v.e_err = ee;
    return v;
  endfunction

  initial begin
    rst_n = 1'b0;
    xa_wr_s = 0; xa_rd_s = 0; wa_ack_s = 0; wa_wr_s = 0;
    xa_wr_data = '0; wa_wr_data = '0;
    model_reset();

    // Directed table: fill/overflow/drain, return register, illegal op, push+pop.
    //             wr wd       rd ack wwr wwd      lvl full val wa       rdv rdd      err
    tbl.push_back(mk(1, 16'h1111, 0, 0, 0, 16'h0000, 1, 0, 1, 16'h1111, 0, 16'h0000, 0));
    tbl.push_back(mk(1, 16'h2222, 0, 0, 0, 16'h0000, 2, 0, 1, 16'h1111, 0, 16'h0000, 0));
    tbl.push_back(mk(1, 16'h3333, 0, 0, 0, 16'h0000, 3, 0, 1, 16'h1111, 0, 16'h0000, 0));
    tbl.push_back(mk(1, 16'h4444, 0, 0, 0, 16'h0000, 4, 1, 1, 16'h1111, 0, 16'h0000, 0));
    tbl.push_back(mk(1, 16'h5555, 0, 0, 0, 16'h0000, 4, 1, 1, 16'h1111, 0, 16'h0000, 1));
    tbl.push_back(mk(0, 16'h0000, 0, 1, 0, 16'h0000, 3, 0, 1, 16'h2222, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 16'h0000, 0, 1, 0, 16'h0000, 2, 0, 1, 16'h3333, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 16'h0000, 0, 1, 0, 16'h0000, 1, 0, 1, 16'h4444, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 16'h0000, 0, 1, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 16'h0000, 0, 1, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 1, 16'hBEEF, 0, 0, 0, 16'h0000, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 16'hBEEF, 0));
    tbl.push_back(mk(0, 16'h0000, 1, 0, 1, 16'hCAFE, 0, 0, 0, 16'h0000, 1, 16'hBEEF, 0));
    tbl.push_back(mk(0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 16'hCAFE, 0));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'hCAFE, 0));
    tbl.push_back(mk(1, 16'h1234, 0, 0, 0, 16'h0000, 1, 0, 1, 16'h1234, 0, 16'hCAFE, 0));
    tbl.push_back(mk(1, 16'h7777, 1, 0, 0, 16'h0000, 1, 0, 1, 16'h1234, 0, 16'hCAFE, 1));
    tbl.push_back(mk(0, 16'h0000, 0, 1, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'hCAFE, 0));
    tbl.push_back(mk(1, 16'h0001, 0, 0, 0, 16'h0000, 1, 0, 1, 16'h0001, 0, 16'hCAFE, 0));
    tbl.push_back(mk(1, 16'h0002, 0, 0, 0, 16'h0000, 2, 0, 1, 16'h0001, 0, 16'hCAFE, 0));
    tbl.push_back(mk(1, 16'hAAAA, 0, 1, 0, 16'h0000, 2, 0, 1, 16'h0002, 0, 16'hCAFE, 0));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(0, '0, 0, 0, 0, '0, "idle");

    // Table-driven vectors, checked against both the table and the model.
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].wr, tbl[i].wd, tbl[i].rd, tbl[i].ack, tbl[i].wwr, tbl[i].wwd,
           $sformatf("vec%0d", i));
      chk($sformatf("tbl%0d.level", i), 32'(level), 32'(tbl[i].e_level));
      chk($sformatf("tbl%0d.full", i), 32'(xa_full), 32'(tbl[i].e_full));
      chk($sformatf("tbl%0d.valid", i), 32'(wa_valid_s), 32'(tbl[i].e_valid));
      chk($sformatf("tbl%0d.wa_data", i), 32'(wa_data), 32'(tbl[i].e_wa));
      chk($sformatf("tbl%0d.rd_valid", i), 32'(xa_rd_valid_s), 32'(tbl[i].e_rdv));
      chk($sformatf("tbl%0d.rd_data", i), 32'(xa_rd_data), 32'(tbl[i].e_rdd));
      chk($sformatf("tbl%0d.err", i), 32'(xa_err_s), 32'(tbl[i].e_err));
    end

    // Pointer wrap: keep level at 2 while streaming push+pop for 12 cycles.
    for (int i = 0; i < 12; i++)
      step(1, 16'(16'h0100 + i), 0, 1, 0, '0, "wrap");
    // Drain and ensure the 0x7777 word never shows up.
    while (q.size() != 0) begin
      step(0, '0, 0, 1, 0, '0, "drain");
      chk("no7777", 32'(wa_data == 16'h7777), 32'h0);
    end

    // Async reset mid-burst at level 3.
    for (int i = 0; i < 3; i++) step(1, 16'(16'h0A00 + i), 0, 0, 0, '0, "preburst");
    chk("pre_rst.level", 32'(level), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async.level", 32'(level), 32'd0);
    chk("async.valid", 32'(wa_valid_s), 32'd0);
    chk("async.wa_data", 32'(wa_data), 32'd0);
    chk("async.rd_data", 32'(xa_rd_data), 32'd0);
    #2;
    rst_n = 1'b1;
    step(0, '0, 0, 1, 0, '0, "ack_after_rst");
    step(0, '0, 1, 0, 0, '0, "rd_after_rst");

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 60, 16'($urandom), $urandom_range(0, 99) < 20,
           $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 30, 16'($urandom),
           "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
